// File: rtl/timer_array.sv
// Multi-channel memory-mapped down-counter timer block with per-channel prescaler,
// one-shot / auto-reload modes and a sticky write-1-to-clear interrupt status.
module timer_array #(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 32,
  parameter logic [31:0] BASE   = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       address,
  input  logic              WE,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              IRQ,
  output logic [NUM_CH-1:0] irq_vec
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT} state_t;

  localparam logic [29:0]      BASE_W = BASE[31:2];
  localparam logic [29:0]      SPAN_W = 30'((NUM_CH + 1) * 4);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [29:0] off;
  logic        in_block;
  logic [3:0]  sel;
  logic [1:0]  word;

  logic [NUM_CH-1:0] en_q, mode_q, im_q, restart_q, status_q;
  logic [7:0]        psc_q     [NUM_CH];
  logic [7:0]        pre_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  preset_q  [NUM_CH];
  logic [CNT_W-1:0]  count_q   [NUM_CH];
  state_t            state_q   [NUM_CH];
  state_t            state_d   [NUM_CH];

  logic [NUM_CH-1:0] wr_ctrl, wr_preset, load, run, tick, expire;
  logic              wr_status;
  logic              unused_data;

  assign off         = address - BASE_W;
  assign in_block    = off < SPAN_W;
  assign sel         = off[5:2];
  assign word        = off[1:0];
  assign unused_data = ^dataIn;

  always_comb begin
    wr_status = WE && in_block && (sel == 4'(NUM_CH)) && (word == 2'd0);
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ctrl[i]   = WE && in_block && (sel == 4'(i)) && (word == 2'd0);
      wr_preset[i] = WE && in_block && (sel == 4'(i)) && (word == 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
    end
  end

  // A pending restart pre-empts any tick so a reload always starts from a clean LOAD.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (en_q[i]) state_d[i] = LOAD;
        LOAD:    state_d[i] = CNT;
        CNT: begin
          if (!en_q[i])                    state_d[i] = IDLE;
          else if (restart_q[i])           state_d[i] = LOAD;
          else if (expire[i] && !mode_q[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load[i]   = (state_q[i] == LOAD);
      run[i]    = (state_q[i] == CNT) && en_q[i] && !restart_q[i];
      tick[i]   = run[i] && (pre_cnt_q[i] == psc_q[i]);
      expire[i] = tick[i] && (count_q[i] <= ONE);
    end
  end

  // CPU CTRL writes take priority over the one-shot EN auto-clear; STATUS set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= '0;
      mode_q    <= '0;
      im_q      <= '0;
      restart_q <= '0;
      status_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        psc_q[i]     <= '0;
        pre_cnt_q[i] <= '0;
        preset_q[i]  <= '0;
        count_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        restart_q[i] <= wr_ctrl[i] && dataIn[0];
        if (wr_ctrl[i]) begin
          en_q[i]   <= dataIn[0];
          mode_q[i] <= dataIn[1];
          im_q[i]   <= dataIn[3];
          psc_q[i]  <= dataIn[15:8];
        end else if (expire[i] && !mode_q[i]) begin
          en_q[i] <= 1'b0;
        end
        if (wr_preset[i]) preset_q[i] <= dataIn[CNT_W-1:0];
        if (load[i]) begin
          count_q[i]   <= preset_q[i];
          pre_cnt_q[i] <= '0;
        end else if (run[i]) begin
          pre_cnt_q[i] <= tick[i] ? 8'd0 : pre_cnt_q[i] + 8'd1;
          if (tick[i]) begin
            if (expire[i]) count_q[i] <= mode_q[i] ? preset_q[i] : '0;
            else           count_q[i] <= count_q[i] - ONE;
          end
        end
      end
      status_q <= (status_q & ~(wr_status ? dataIn[NUM_CH-1:0] : '0)) | expire;
    end
  end

  always_comb begin
    dataOut = '0;
    if (in_block) begin
      if (sel == 4'(NUM_CH)) begin
        if (word == 2'd0) dataOut = 32'(status_q);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel == 4'(i)) begin
            case (word)
              2'd0:    dataOut = {16'b0, psc_q[i], 4'b0, im_q[i], 1'b0, mode_q[i], en_q[i]};
              2'd1:    dataOut = 32'(preset_q[i]);
              2'd2:    dataOut = 32'(count_q[i]);
              default: dataOut = '0;
            endcase
          end
        end
      end
    end
  end

  assign irq_vec = status_q & im_q;
  assign IRQ     = |irq_vec;

endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
- Multi-channel, memory-mapped timer/counter; parametrised successor of the single-channel TC timers on the CPU's data bus behind the Bridge.
- NUM_CH independent down-counters, each with its own 8-bit prescaler, one-shot and auto-reload modes, and a per-channel interrupt mask.
- A sticky write-1-to-clear IRQ status register is aggregated into a single IRQ line for the CPU's external interrupt vector.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, counter/preset width in bits (8..32); upper dataIn bits are ignored, upper dataOut bits read 0.
- BASE, 32'h0000_7F00, byte base address; word-aligned; block spans (NUM_CH+1)*16 bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  30  word address (CPU_addr[31:2])
- WE  in  1  write enable, already qualified by the Bridge
- dataIn  in  32  write data
- dataOut  out  32  read data, combinational from address
- IRQ  out  1  OR of (status[i] & IM[i]) over all channels
- irq_vec  out  NUM_CH  per-channel status[i] & IM[i]

Behaviour:
- Register map. Channel i occupies BASE + 16*i:
  - +0 CTRL, R/W: [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [3] IM, [15:8] PSC. Other bits read 0.
  - +4 PRESET, R/W.
  - +8 COUNT, read-only; writes are ignored.
  - +12 reads 0.
- Global registers at BASE + 16*NUM_CH: +0 STATUS ([NUM_CH-1:0], read; writing 1 clears a bit); +4..+12 read 0.
- Addresses outside the block read 0; writes to them have no effect.
- Reset: all CTRL, PRESET, COUNT, STATUS, prescaler counters and FSMs cleared; IRQ=0, irq_vec=0.
- Per-channel FSM (IDLE, LOAD, CNT):
  - IDLE: go to LOAD in the cycle after EN is 1 (set by a CTRL write).
  - LOAD: COUNT<=PRESET, prescaler<=0, go to CNT. COUNT is visible one cycle after LOAD.
  - CNT, EN=0: return to IDLE; COUNT holds its value.
  - CNT, EN=1, prescaler tick: a tick occurs when prescaler==PSC; the prescaler then resets to 0, otherwise it increments. PSC=0 ticks every cycle.
  - On a tick with COUNT>1: COUNT decrements.
  - On a tick with COUNT<=1 (expire): STATUS[i]<=1.
    - One-shot: COUNT<=0, EN<=0, go to IDLE.
    - Auto-reload: COUNT<=PRESET, stay in CNT.
- PRESET=0 or 1: expires on the first tick. Period in cycles = max(PRESET,1)*(PSC+1).
- Writing PRESET while in CNT does not change COUNT until the next LOAD or reload.
- Writing CTRL with EN=1 while in CNT restarts the channel: it goes to LOAD next cycle. A CTRL write is detected as a restart regardless of the previous EN value.
- Collisions in the same cycle:
  - CPU CTRL write vs one-shot EN auto-clear: the CPU write wins.
  - STATUS clear vs expire of the same channel: the set wins.
- IRQ and irq_vec are combinational from registered STATUS and IM, asserted in the cycle after expire. Clearing IM masks the output but keeps STATUS; setting IM later re-raises IRQ.
- Channels are fully independent; several may expire in the same cycle and all set their STATUS bits.
- Reset mid-count: all state clears next edge; no IRQ.

Test Plan:
- Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM, PSC=0) → COUNT 5,4,3,2,1 over successive cycles; STATUS[0]=1 and IRQ=1 the cycle after the COUNT=1 tick; CTRL reads 0x8; COUNT=0.
- Ch1 PRESET=3, PSC=2, auto-reload, IM=1 → STATUS[1] sets every 9 cycles; write STATUS=0x2 between expiries clears IRQ; the next expiry re-raises it.
- Ch2 one-shot with IM=0 → STATUS[2]=1 while IRQ=0; set IM=1 → IRQ=1 combinationally; write STATUS=0x4 in the same cycle as a ch2 expire → bit remains 1.
- Two channels with PRESET=4 started in the same cycle → both STATUS bits set in the same cycle; irq_vec=0b0011.
- Read BASE+0x8 after a write to it → returns the live COUNT, unchanged by the write; reads of unmapped offset +12 and of BASE+16*(NUM_CH+1) → 0.
- Assert reset while ch0 has COUNT=2 → next cycle all registers read 0, IRQ=0, and no expire occurs afterwards.
